// File: rtl/fare_pkg.sv
// Shared types, default tariff constants and saturating fare arithmetic for the fare meter.
package fare_pkg;

    localparam int unsigned COST_W = 16;
    localparam int unsigned SUM_W  = COST_W + 1;

    localparam int unsigned DEF_BASE_FARE   = 10;
    localparam int unsigned DEF_BASE_PULSES = 30;
    localparam int unsigned DEF_KM_PULSES   = 10;
    localparam int unsigned DEF_UNIT_PRICE  = 2;
    localparam int unsigned DEF_WAIT_TICKS  = 50_000_000;
    localparam int unsigned DEF_WAIT_PRICE  = 1;
    localparam int unsigned DEF_COST_MAX    = 999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Add with one spare bit so the sum cannot wrap, then clamp to the ceiling.
    function automatic logic [COST_W-1:0] sat_add(input logic [COST_W-1:0] a,
                                                  input logic [SUM_W-1:0]  inc,
                                                  input logic [SUM_W-1:0]  lim);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, a} + inc;
        return (sum > lim) ? lim[COST_W-1:0] : sum[COST_W-1:0];
    endfunction

endpackage

// File: rtl/fare_tick_counter.sv
// Terminal-count counter: counts inc cycles modulo N, tc marks the inc that wraps it.
module fare_tick_counter
    import fare_pkg::*;
#(
    parameter int unsigned N = 10,
    parameter int unsigned W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    // tc is combinational so the charge lands on the same edge as the wrapping inc.
    assign tc = inc && !clr && (cnt == LAST);

    // Count register; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/fare_meter.sv
// Trip fare accumulator: base fare, per-distance charges, waiting charges, saturating cost.
module fare_meter
    import fare_pkg::*;
#(
    parameter int unsigned BASE_FARE   = DEF_BASE_FARE,
    parameter int unsigned BASE_PULSES = DEF_BASE_PULSES,
    parameter int unsigned KM_PULSES   = DEF_KM_PULSES,
    parameter int unsigned UNIT_PRICE  = DEF_UNIT_PRICE,
    parameter int unsigned WAIT_TICKS  = DEF_WAIT_TICKS,
    parameter int unsigned WAIT_PRICE  = DEF_WAIT_PRICE,
    parameter int unsigned COST_MAX    = DEF_COST_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              dist_pulse,
    output logic [COST_W-1:0] cost,
    output logic [COST_W-1:0] distance,
    output logic              running,
    output logic              done
);

    localparam int unsigned       WAIT_W    = $clog2(WAIT_TICKS);
    localparam int unsigned       KM_W      = $clog2(KM_PULSES) + 1;
    localparam logic [SUM_W-1:0]  COST_LIM  = SUM_W'(COST_MAX);
    localparam logic [SUM_W-1:0]  BASE_P    = SUM_W'(BASE_PULSES);
    localparam logic [COST_W-1:0] BASE_COST =
        COST_W'((BASE_FARE < COST_MAX) ? BASE_FARE : COST_MAX);
    localparam logic [COST_W-1:0] DIST_MAX  = '1;

    state_t           state;
    logic             load;
    logic             run_act;
    logic             km_inc;
    logic             km_clr;
    logic             km_tc;
    logic             wait_inc;
    logic             wait_clr;
    logic             wait_tc;
    logic [SUM_W-1:0] charge_inc;

    // Strobe decode in priority order: clear, stop, start, then pulse/wait charging.
    always_comb begin
        load       = !clear && start && (state == IDLE || state == DONE);
        run_act    = !clear && !stop && (state == RUN);
        km_inc     = run_act && dist_pulse && ({1'b0, distance} >= BASE_P);
        km_clr     = clear || load;
        wait_inc   = run_act && !dist_pulse;
        wait_clr   = clear || load || (run_act && dist_pulse);
        charge_inc = km_tc ? SUM_W'(UNIT_PRICE) : SUM_W'(WAIT_PRICE);
    end

    fare_tick_counter #(.N(KM_PULSES), .W(KM_W)) u_km_div (
        .clk (clk),
        .rst (rst),
        .inc (km_inc),
        .clr (km_clr),
        .tc  (km_tc)
    );

    fare_tick_counter #(.N(WAIT_TICKS), .W(WAIT_W)) u_wait_tmr (
        .clk (clk),
        .rst (rst),
        .inc (wait_inc),
        .clr (wait_clr),
        .tc  (wait_tc)
    );

    // Trip FSM with registered fare, distance and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cost     <= '0;
            distance <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else if (clear) begin
            state    <= IDLE;
            cost     <= '0;
            distance <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        cost     <= BASE_COST;
                        distance <= '0;
                        running  <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        if (dist_pulse && distance != DIST_MAX) begin
                            distance <= distance + COST_W'(1);
                        end
                        if (km_tc || wait_tc) begin
                            cost <= sat_add(cost, charge_inc, COST_LIM);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    cost     <= '0;
                    distance <= '0;
                    running  <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fare_meter.sv
// Directed bench for fare_meter: a default-ceiling instance and a COST_MAX=13 instance share stimulus.
module tb_fare_meter;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        clear;
    logic        dist_pulse;
    logic [15:0] cost;
    logic [15:0] distance;
    logic        running;
    logic        done;
    logic [15:0] cost_s;
    logic [15:0] distance_s;
    logic        running_s;
    logic        done_s;

    int checks   = 0;
    int failures = 0;

    fare_meter #(.WAIT_TICKS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .dist_pulse (dist_pulse),
        .cost       (cost),
        .distance   (distance),
        .running    (running),
        .done       (done)
    );

    fare_meter #(.WAIT_TICKS(8), .COST_MAX(13)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .dist_pulse (dist_pulse),
        .cost       (cost_s),
        .distance   (distance_s),
        .running    (running_s),
        .done       (done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // One pulse followed by one idle cycle.
    task automatic spaced_pulse();
        dist_pulse = 1'b1;
        tick();
        dist_pulse = 1'b0;
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        clear      = 1'b0;
        dist_pulse = 1'b0;
        ticks(2);
        check("rst_cost",      32'(cost), 0);
        check("rst_distance",  32'(distance), 0);
        check("rst_running",   32'(running), 0);
        check("rst_done",      32'(done), 0);
        check("rst_sat_state", 32'({running_s, done_s, cost_s, distance_s}), 0);
        rst = 1'b0;
        tick();

        // Pulses in IDLE do not count.
        dist_pulse = 1'b1;
        tick();
        dist_pulse = 1'b0;
        check("idle_distance", 32'(distance), 0);

        // Distance pricing: base covers 30 pulses, then 2 per 10 pulses.
        do_start();
        check("start_running", 32'(running), 1);
        check("start_cost",    32'(cost), 10);
        check("start_dist",    32'(distance), 0);
        for (int i = 1; i <= 50; i++) begin
            spaced_pulse();
            if (i == 30) begin
                check("p30_cost", 32'(cost), 10);
                check("p30_dist", 32'(distance), 30);
            end
            if (i == 39) check("p39_cost", 32'(cost), 10);
            if (i == 40) begin
                check("p40_cost",     32'(cost), 12);
                check("p40_sat_cost", 32'(cost_s), 12);
            end
            if (i == 50) begin
                check("p50_cost",     32'(cost), 14);
                check("p50_sat_cost", 32'(cost_s), 13);
                check("p50_dist",     32'(distance), 50);
            end
        end

        // Asynchronous reset in the middle of a trip.
        check("pre_rst_cost", 32'(cost), 14);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_cost",    32'(cost), 0);
        check("async_rst_dist",    32'(distance), 0);
        check("async_rst_running", 32'(running), 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_running", 32'(running), 0);
        check("post_rst_done",    32'(done), 0);
        check("post_rst_cost",    32'(cost), 0);

        // Waiting charges every 8 pulse-free RUN cycles.
        do_start();
        ticks(7);
        check("wait_n7_cost",  32'(cost), 10);
        tick();
        check("wait_n8_cost",  32'(cost), 11);
        ticks(7);
        check("wait_n15_cost", 32'(cost), 11);
        tick();
        check("wait_n16_cost", 32'(cost), 12);
        check("wait_sat_cost", 32'(cost_s), 12);
        do_stop();
        check("stop_done",    32'(done), 1);
        check("stop_running", 32'(running), 0);

        // A pulse at N+5 restarts the waiting timer: first charge at N+13.
        do_start();
        check("restart_cost", 32'(cost), 10);
        check("restart_dist", 32'(distance), 0);
        check("restart_done", 32'(done), 0);
        ticks(4);
        dist_pulse = 1'b1;
        tick();
        dist_pulse = 1'b0;
        check("wait_pulse_dist", 32'(distance), 1);
        ticks(7);
        check("wait_n12_cost", 32'(cost), 10);
        tick();
        check("wait_n13_cost", 32'(cost), 11);

        // Stop together with pulse 40: pulse dropped, values frozen.
        do_stop();
        do_start();
        for (int i = 1; i <= 39; i++) spaced_pulse();
        check("p39b_cost", 32'(cost), 10);
        dist_pulse = 1'b1;
        stop       = 1'b1;
        tick();
        dist_pulse = 1'b0;
        stop       = 1'b0;
        check("stopdrop_cost", 32'(cost), 10);
        check("stopdrop_dist", 32'(distance), 39);
        check("stopdrop_done", 32'(done), 1);
        for (int i = 0; i < 100; i++) begin
            dist_pulse = (i % 3 == 0);
            tick();
        end
        dist_pulse = 1'b0;
        check("hold_cost", 32'(cost), 10);
        check("hold_dist", 32'(distance), 39);
        do_stop();
        check("stop_in_done", 32'(done), 1);
        do_start();
        check("fresh_cost",    32'(cost), 10);
        check("fresh_dist",    32'(distance), 0);
        check("fresh_running", 32'(running), 1);

        // Start while running is ignored (distance not reloaded).
        dist_pulse = 1'b1;
        tick();
        dist_pulse = 1'b0;
        do_start();
        check("start_in_run_dist",    32'(distance), 1);
        check("start_in_run_running", 32'(running), 1);

        // Clear beats start in DONE.
        do_stop();
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        check("clear_cost",    32'(cost), 0);
        check("clear_running", 32'(running), 0);
        check("clear_done",    32'(done), 0);

        // Clear with a pulse in RUN: pulse dropped, outputs zeroed.
        do_start();
        clear      = 1'b1;
        dist_pulse = 1'b1;
        tick();
        clear      = 1'b0;
        dist_pulse = 1'b0;
        check("clear_run_dist",    32'(distance), 0);
        check("clear_run_running", 32'(running), 0);

        // Saturation: COST_MAX=13 gives 10, 12, 13, 13.
        do_start();
        for (int i = 1; i <= 60; i++) begin
            spaced_pulse();
            if (i == 30) check("sat_p30", 32'(cost_s), 10);
            if (i == 40) check("sat_p40", 32'(cost_s), 12);
            if (i == 50) check("sat_p50", 32'(cost_s), 13);
            if (i == 60) check("sat_p60", 32'(cost_s), 13);
        end
        check("p60_cost", 32'(cost), 16);
        check("p60_dist", 32'(distance), 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
